// File: rtl/fdc_pkg.sv
// Shared FDC status/control word layout, host opcodes and sequencer state encoding.
// Used by nec765, the host bridge and fdc_host_sequencer so all three agree on the bit positions.
package fdc_pkg;

   // fdc_sr: request word from the FDC core
   localparam int SR_READ_LSB   = 24;
   localparam int SR_WRITE_LSB  = 26;
   localparam int SR_READID_LSB = 28;
   localparam int SR_SEEK_LSB   = 30;
   localparam int SR_ACK        = 23;
   localparam int SR_ADDR_W     = 16;

   // fdc_cr: completion word back to the FDC core
   localparam int CR_SECTID_LSB   = 24;
   localparam int CR_HEAD_LSB     = 8;
   localparam int CR_DISKIN_LSB   = 5;
   localparam int CR_DONE         = 4;
   localparam int CR_ERROR        = 3;
   localparam int CR_WPERR        = 2;
   localparam int CR_SEEKDONE_LSB = 0;

   typedef enum logic [1:0] {
      OP_SEEK   = 2'd0,
      OP_READID = 2'd1,
      OP_READ   = 2'd2,
      OP_WRITE  = 2'd3
   } host_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_DONE_HOLD
   } seq_state_e;

   typedef struct packed {
      host_op_e          op;
      logic              drive;
      logic [SR_ADDR_W-1:0] addr;
   } host_cmd_t;

   // Position in fdc_sr of the request bit for a given op and drive.
   function automatic logic [4:0] sr_req_bit(input host_op_e op, input logic drive);
      logic [4:0] base;
      case (op)
         OP_SEEK:   base = 5'(SR_SEEK_LSB);
         OP_READID: base = 5'(SR_READID_LSB);
         OP_WRITE:  base = 5'(SR_WRITE_LSB);
         default:   base = 5'(SR_READ_LSB);
      endcase
      return base + {4'd0, drive};
   endfunction

endpackage

// File: rtl/fdc_timeout.sv
// Loadable down-counter: load starts a run, expire pulses for one cycle when it reaches zero, then idles.
// A load-to-expire run lasts load_val+1 cycles; clear returns it to idle without expiring.
module fdc_timeout #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         clear,
   output logic         expire
);

   logic         active_q;
   logic [W-1:0] cnt_q;

   assign expire = active_q && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else if (load) begin
         active_q <= 1'b1;
         cnt_q    <= load_val;
      end else if (clear || expire) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else if (active_q) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/fdc_host_sequencer.sv
// Turns FDC request bits into one host command at a time (valid/ready), waits for response or timeout, reports on fdc_cr.
// Request -> host_cmd_valid 1 cycle; host_rsp_valid -> fdc_cr done 1 cycle; valid holds until ready, withdrawn if request drops.
module fdc_host_sequencer
   import fdc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 24'd8000000,
   parameter int unsigned TO_W           = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] fdc_sr,
   output logic [31:0] fdc_cr,
   input  logic [1:0]  disk_in,
   output logic        host_cmd_valid,
   input  logic        host_cmd_ready,
   output logic [1:0]  host_cmd_op,
   output logic        host_cmd_drive,
   output logic [15:0] host_cmd_addr,
   input  logic        host_rsp_valid,
   input  logic        host_rsp_error,
   input  logic        host_rsp_wperr,
   input  logic [7:0]  host_rsp_sectid,
   input  logic [7:0]  host_rsp_head,
   output logic [7:0]  timeout_cnt
);

   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

   seq_state_e state_q, state_d;
   host_cmd_t  cmd_q;
   logic       last_drive_q;
   logic       rsp_err_q;
   logic       rsp_wperr_q;
   logic [7:0] sectid_q;
   logic [7:0] head_q;
   logic [7:0] timeout_cnt_q;

   logic [7:0] req;
   logic       pending;
   host_op_e   sel_op;
   logic [1:0] sel_pair;
   logic       sel_drive;
   logic       latched_req;
   logic       do_latch;
   logic       do_accept;
   logic       do_rsp;
   logic       do_timeout;
   logic       to_expire;
   logic       unused_sr;

   assign req       = fdc_sr[SR_SEEK_LSB+1:SR_READ_LSB];
   assign pending   = !fdc_sr[SR_ACK] && (req != 8'd0);
   assign unused_sr = ^fdc_sr[SR_ACK-1:SR_ADDR_W];

   // Fixed op priority, then round-robin between drives only when both ask for the winning op.
   always_comb begin
      sel_op   = OP_READ;
      sel_pair = req[1:0];
      if (req[7:6] != 2'b00) begin
         sel_op   = OP_SEEK;
         sel_pair = req[7:6];
      end else if (req[5:4] != 2'b00) begin
         sel_op   = OP_READID;
         sel_pair = req[5:4];
      end else if (req[3:2] != 2'b00) begin
         sel_op   = OP_WRITE;
         sel_pair = req[3:2];
      end
      case (sel_pair)
         2'b01:   sel_drive = 1'b0;
         2'b10:   sel_drive = 1'b1;
         default: sel_drive = !last_drive_q;
      endcase
   end

   assign latched_req = fdc_sr[sr_req_bit(cmd_q.op, cmd_q.drive)];

   always_comb begin
      state_d    = state_q;
      do_latch   = 1'b0;
      do_accept  = 1'b0;
      do_rsp     = 1'b0;
      do_timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending) begin
               do_latch = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A handshake already completed takes precedence over a same-cycle withdrawal.
            if (host_cmd_ready) begin
               do_accept = 1'b1;
               state_d   = ST_WAIT_RSP;
            end else if (!latched_req) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_RSP: begin
            if (host_rsp_valid) begin
               do_rsp  = 1'b1;
               state_d = ST_DONE_HOLD;
            end else if (to_expire) begin
               do_timeout = 1'b1;
               state_d    = ST_DONE_HOLD;
            end
         end
         ST_DONE_HOLD: begin
            if (!latched_req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q         <= '0;
         last_drive_q  <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_wperr_q   <= 1'b0;
         sectid_q      <= 8'd0;
         head_q        <= 8'd0;
         timeout_cnt_q <= 8'd0;
      end else begin
         if (do_latch) begin
            cmd_q.op     <= sel_op;
            cmd_q.drive  <= sel_drive;
            cmd_q.addr   <= fdc_sr[SR_ADDR_W-1:0];
            last_drive_q <= sel_drive;
         end
         // Seeks report no sector, so they leave the sectid/head fields untouched.
         if (do_rsp) begin
            rsp_err_q   <= host_rsp_error;
            rsp_wperr_q <= host_rsp_wperr;
            if (cmd_q.op != OP_SEEK) begin
               sectid_q <= host_rsp_sectid;
               head_q   <= host_rsp_head;
            end
         end
         if (do_timeout) begin
            rsp_err_q   <= 1'b1;
            rsp_wperr_q <= 1'b0;
            if (cmd_q.op != OP_SEEK) begin
               sectid_q <= 8'd0;
               head_q   <= 8'd0;
            end
            if (timeout_cnt_q != 8'hFF) begin
               timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
         end
      end
   end

   fdc_timeout #(
      .W(TO_W)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (do_accept),
      .load_val (TO_LOAD),
      .clear    (do_rsp),
      .expire   (to_expire)
   );

   always_comb begin
      fdc_cr = 32'd0;
      fdc_cr[CR_SECTID_LSB +: 8] = sectid_q;
      fdc_cr[CR_HEAD_LSB +: 8]   = head_q;
      fdc_cr[CR_DISKIN_LSB +: 2] = disk_in;
      if (state_q == ST_DONE_HOLD) begin
         fdc_cr[CR_ERROR] = rsp_err_q;
         if (cmd_q.op == OP_SEEK) begin
            fdc_cr[CR_SEEKDONE_LSB +: 2] = cmd_q.drive ? 2'b10 : 2'b01;
         end else begin
            fdc_cr[CR_DONE]  = 1'b1;
            fdc_cr[CR_WPERR] = rsp_wperr_q;
         end
      end
   end

   assign host_cmd_valid = (state_q == ST_ISSUE);
   assign host_cmd_op    = cmd_q.op;
   assign host_cmd_drive = cmd_q.drive;
   assign host_cmd_addr  = cmd_q.addr;
   assign timeout_cnt    = timeout_cnt_q;

endmodule

// File: tb/tb_fdc_host_sequencer.sv
// Bench for fdc_host_sequencer with a short timeout; directed scenarios followed by random transactions.
module tb_fdc_host_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fdc_sr;
   logic [31:0] fdc_cr;
   logic [1:0]  disk_in;
   logic        host_cmd_valid;
   logic        host_cmd_ready;
   logic [1:0]  host_cmd_op;
   logic        host_cmd_drive;
   logic [15:0] host_cmd_addr;
   logic        host_rsp_valid;
   logic        host_rsp_error;
   logic        host_rsp_wperr;
   logic [7:0]  host_rsp_sectid;
   logic [7:0]  host_rsp_head;
   logic [7:0]  timeout_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic       last_m;
   logic [7:0] sectid_m;
   logic [7:0] head_m;
   int         to_m;

   always #5 clk = ~clk;

   fdc_host_sequencer #(
      .TIMEOUT_CYCLES(16),
      .TO_W(24)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fdc_sr          (fdc_sr),
      .fdc_cr          (fdc_cr),
      .disk_in         (disk_in),
      .host_cmd_valid  (host_cmd_valid),
      .host_cmd_ready  (host_cmd_ready),
      .host_cmd_op     (host_cmd_op),
      .host_cmd_drive  (host_cmd_drive),
      .host_cmd_addr   (host_cmd_addr),
      .host_rsp_valid  (host_rsp_valid),
      .host_rsp_error  (host_rsp_error),
      .host_rsp_wperr  (host_rsp_wperr),
      .host_rsp_sectid (host_rsp_sectid),
      .host_rsp_head   (host_rsp_head),
      .timeout_cnt     (timeout_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // fdc_cr with no completion flags: retained sectid/head plus live disk_in
   function automatic logic [31:0] idle_cr();
      return {sectid_m, 8'h00, head_m, 1'b0, disk_in, 5'b00000};
   endfunction

   // Highest-priority requested op; drive chosen by round-robin only when both drives ask.
   function automatic void pick(input logic [31:0] sr, input logic last,
                                output logic [1:0] op, output logic drv, output int bitpos);
      int          b;
      logic [1:0]  code;
      logic [1:0]  pair;
      op = 2'd2; drv = 1'b0; bitpos = 24;
      for (int p = 3; p >= 0; p--) begin
         case (p)
            3:       begin b = 24; code = 2'd2; end  // read
            2:       begin b = 26; code = 2'd3; end  // write
            1:       begin b = 28; code = 2'd1; end  // readid
            default: begin b = 30; code = 2'd0; end  // seek
         endcase
         pair = {sr[b+1], sr[b]};
         if (pair != 2'b00) begin
            op     = code;
            drv    = (pair == 2'b11) ? !last : pair[1];
            bitpos = b + int'(drv);
         end
      end
   endfunction

   task automatic do_txn(input logic [31:0] sr, input int rdy_dly, input bit give_rsp, input int rsp_dly,
                         input bit r_err, input bit r_wp, input logic [7:0] r_sid, input logic [7:0] r_head);
      logic [1:0]  e_op;
      logic        e_drv;
      int          e_bit;
      logic        e_err;
      logic        e_wp;
      logic [31:0] e_cr;
      int          hold;
      pick(sr, last_m, e_op, e_drv, e_bit);
      last_m = e_drv;
      fdc_sr = sr;
      step();
      check("cmd_valid", 32'(host_cmd_valid), 32'd1);
      check("cmd_op",    32'(host_cmd_op),    32'(e_op));
      check("cmd_drive", 32'(host_cmd_drive), 32'(e_drv));
      check("cmd_addr",  32'(host_cmd_addr),  32'(sr[15:0]));
      for (int i = 0; i < rdy_dly; i++) begin
         step();
         check("cmd_stall", {13'd0, host_cmd_valid, host_cmd_op, host_cmd_drive, host_cmd_addr},
               {13'd0, 1'b1, e_op, e_drv, sr[15:0]});
      end
      host_cmd_ready = 1'b1;
      step();
      host_cmd_ready = 1'b0;
      check("valid_after_accept", 32'(host_cmd_valid), 32'd0);
      // other request bits wander while waiting; the latched one stays up
      fdc_sr = (fdc_sr ^ {8'($urandom), 24'h0}) | (32'(1) << e_bit);
      if (give_rsp) begin
         for (int i = 0; i < rsp_dly; i++) step();
         check("no_early_done", fdc_cr, idle_cr());
         host_rsp_valid  = 1'b1;
         host_rsp_error  = r_err;
         host_rsp_wperr  = r_wp;
         host_rsp_sectid = r_sid;
         host_rsp_head   = r_head;
         step();
         host_rsp_valid  = 1'b0;
      end else begin
         for (int i = 0; i < 15; i++) step();
         check("no_early_timeout", fdc_cr, idle_cr());
         step();
      end
      e_err = give_rsp ? r_err : 1'b1;
      e_wp  = give_rsp ? r_wp  : 1'b0;
      if (!give_rsp && to_m < 255) to_m++;
      e_cr = idle_cr();
      if (e_op == 2'd0) begin
         e_cr[int'(e_drv)] = 1'b1;
         e_cr[3] = e_err;
      end else begin
         sectid_m = give_rsp ? r_sid  : 8'h00;
         head_m   = give_rsp ? r_head : 8'h00;
         e_cr = idle_cr();
         e_cr[4] = 1'b1;
         e_cr[3] = e_err;
         e_cr[2] = e_wp;
      end
      check("done_cr", fdc_cr, e_cr);
      check("timeout_cnt", 32'(timeout_cnt), 32'(to_m));
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
         host_rsp_valid  = 1'b1;
         host_rsp_error  = 1'($urandom);
         host_rsp_wperr  = 1'($urandom);
         host_rsp_sectid = 8'($urandom);
         host_rsp_head   = 8'($urandom);
         step();
         host_rsp_valid = 1'b0;
         check("done_hold", fdc_cr, e_cr);
      end
      fdc_sr = (fdc_sr & ~(32'(1) << e_bit)) | 32'h0080_0000;
      step();
      check("done_cleared", fdc_cr, idle_cr());
      check("idle_while_ack", 32'(host_cmd_valid), 32'd0);
      fdc_sr = 32'd0;
      step();
      check("idle_after", 32'(host_cmd_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      fdc_sr = 32'd0;
      disk_in = 2'b10;
      host_cmd_ready = 1'b0;
      host_rsp_valid = 1'b1;
      host_rsp_error = 1'b1;
      host_rsp_wperr = 1'b1;
      host_rsp_sectid = 8'h5A;
      host_rsp_head = 8'hA5;
      last_m = 1'b0; sectid_m = 8'h00; head_m = 8'h00; to_m = 0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      host_rsp_valid = 1'b0;
      check("rst_cr",      fdc_cr, 32'h0000_0040);
      check("rst_valid",   32'(host_cmd_valid), 32'd0);
      check("rst_fields",  {13'd0, host_cmd_op, host_cmd_drive, host_cmd_addr}, 32'd0);
      check("rst_tocnt",   32'(timeout_cnt), 32'd0);
      step();
      check("stray_rsp_ignored", fdc_cr, 32'h0000_0040);

      // read d0, track 0x0C sector 3
      do_txn(32'h0100_0C03, 0, 1, 2, 1'b0, 1'b0, 8'hC3, 8'h00);
      check("read_sectid", 32'(fdc_cr[31:24]), 32'h0000_00C3);
      // seek d1, host stalls 10 cycles
      do_txn(32'h8000_0207, 10, 1, 3, 1'b0, 1'b0, 8'h11, 8'h22);
      // d0 read, then both drives: d1 first, then d0
      do_txn(32'h0100_0001, 1, 1, 0, 1'b0, 1'b0, 8'h01, 8'h00);
      do_txn(32'h0300_0102, 0, 1, 1, 1'b0, 1'b0, 8'h02, 8'h01);
      check("rr_second_d1", 32'(last_m), 32'd1);
      do_txn(32'h0300_0103, 0, 1, 1, 1'b0, 1'b0, 8'h03, 8'h01);
      // no response: error completion exactly 16 cycles after accept
      do_txn(32'h0100_0404, 2, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("first_timeout", 32'(timeout_cnt), 32'd1);
      // response on the same cycle the timeout would fire
      do_txn(32'h0200_0505, 0, 1, 15, 1'b1, 1'b0, 8'h77, 8'h66);

      // withdraw during ISSUE
      begin
         logic [1:0] w_op; logic w_drv; int w_bit;
         pick(32'h0800_0000, last_m, w_op, w_drv, w_bit);
         last_m = w_drv;
         fdc_sr = 32'h0800_0000;
         step();
         check("withdraw_valid", 32'(host_cmd_valid), 32'd1);
         fdc_sr = 32'd0;
         step();
         check("withdraw_dropped", 32'(host_cmd_valid), 32'd0);
         check("withdraw_cr", fdc_cr, idle_cr());
      end

      // reset while waiting for the host, then a late response
      begin
         logic [1:0] w_op; logic w_drv; int w_bit;
         pick(32'h1000_1234, last_m, w_op, w_drv, w_bit);
         last_m = w_drv;
         fdc_sr = 32'h1000_1234;
         step();
         check("rstwait_valid", 32'(host_cmd_valid), 32'd1);
         host_cmd_ready = 1'b1;
         step();
         host_cmd_ready = 1'b0;
         step();
         rst_n = 1'b0;
         fdc_sr = 32'd0;
         step();
         check("valid_in_reset", 32'(host_cmd_valid), 32'd0);
         rst_n = 1'b1;
         host_rsp_valid = 1'b1;
         host_rsp_sectid = 8'hEE;
         step();
         host_rsp_valid = 1'b0;
         last_m = 1'b0; sectid_m = 8'h00; head_m = 8'h00; to_m = 0;
         check("late_rsp_ignored", fdc_cr, idle_cr());
         check("late_rsp_tocnt", 32'(timeout_cnt), 32'd0);
         repeat (20) step();
         check("no_stale_timeout", fdc_cr, idle_cr());
      end

      // write d0 to a protected disk
      do_txn(32'h0400_1105, 0, 1, 4, 1'b0, 1'b1, 8'h05, 8'h01);

      for (int n = 0; n < 60; n++) begin
         logic [31:0] sr;
         disk_in = 2'($urandom);
         sr = {8'($urandom_range(1, 255)), 1'b0, 7'($urandom), 16'($urandom)};
         do_txn(sr, $urandom_range(0, 4), ($urandom_range(0, 4) != 0), $urandom_range(0, 15),
                1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      end

      for (int n = 0; n < 256; n++) begin
         do_txn(32'h0100_0000, 0, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      check("timeout_saturated", 32'(timeout_cnt), 32'd255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
